display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-multiplexing scheduler for the 4-digit 7-segment display of the BCD counter.
- Sequences the shared segment decoder across the four digits with a fixed dwell time and an anode-off dead time between digits.
- Snapshots the counter value once per frame to avoid tearing.
- Applies optional leading-zero blanking.
- Drives the 2-bit digit index, the active-low anode enables and the BCD nibble for the segment decoder.

Parameters:
ON_CYC, 50000, clock cycles each digit is lit (>=1)
BLANK_CYC, 500, clock cycles all anodes are off before each digit (>=0; 0 = no dead time)
CNT_W, 16, width of the dwell counter (must hold max(ON_CYC, BLANK_CYC)-1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
en  in  1  scan enable; low forces display off
lz_en  in  1  leading-zero blanking enable
bcd_in  in  16  counter value; [15:12] = digit 0 (most significant) ... [3:0] = digit 3
digito  out  2  index of the digit currently scheduled (0..3)
an_n  out  4  active-low anode enables {d1,d2,d3,d4}; digito 0 -> 0111, 1 -> 1011, 2 -> 1101, 3 -> 1110
bcd_out  out  4  snapshot nibble for the scheduled digit, to the segment decoder
frame_tick  out  1  one-cycle pulse at each frame wrap (digit 3 -> digit 0)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n). The fixed polarity and asynchronous assertion are decided.
- All outputs are registered.
- Reset values: state = OFF; digito = 0; an_n = 1111; bcd_out = 0; frame_tick = 0; snapshot = 0; dwell counter = 0.
- States: OFF, BLANK, ON.
  - OFF:
    - an_n = 1111; digito = 0; counter = 0.
    - When en = 1 at a clock edge: load snapshot <= bcd_in.
    - Go to BLANK, or directly to ON if BLANK_CYC = 0.
  - BLANK:
    - an_n = 1111 for exactly BLANK_CYC cycles.
    - The counter counts 0..BLANK_CYC-1, then the state goes to ON and the counter clears.
  - ON:
    - an_n = active-low one-hot pattern for digito for exactly ON_CYC cycles, unless the digit is blanked (see below).
    - At the end of the dwell, if digito < 3: digito <= digito + 1 and the state goes to BLANK (or ON if BLANK_CYC = 0).
    - If digito = 3:
      - digito <= 0.
      - snapshot <= bcd_in.
      - frame_tick = 1 for that one cycle.
      - The state goes to BLANK (or ON if BLANK_CYC = 0).
- an_n and bcd_out update on the same edge as digito; there is no skew between index and nibble.
- bcd_out = snapshot nibble selected by digito. Codes A-F are passed through unchanged. bcd_out holds its value during BLANK.
- Leading-zero blanking, evaluated on the snapshot when lz_en = 1:
  - Digit k (k = 0..2) is blanked if nibbles 0..k are all 4'h0.
  - Digit 3 is never blanked.
  - A blanked digit keeps its full ON_CYC timing slot, but an_n = 1111 during that slot.
- Frame timing:
  - Frame period = 4*(BLANK_CYC + ON_CYC) cycles.
  - frame_tick spacing equals the frame period while en stays high.
- Boundary and mid-operation conditions:
  - en low in any state: the next edge gives OFF, an_n = 1111, digito = 0, counter = 0 and no frame_tick. This has priority over the dwell-end transition on the same cycle.
  - en re-asserted: scanning restarts at digit 0 with a fresh snapshot.
  - bcd_in changes mid-frame have no effect until the next snapshot load.
  - lz_en is sampled combinationally against the snapshot each cycle. A mid-frame toggle affects only which anodes are lit, never the timing.
  - reset_n asserted mid-operation: all outputs immediately return to their reset values, asynchronously.
  - reset_n deassertion is synchronized by the integrator; the block restarts from OFF.
  - The counter never exceeds the terminal value of the current state; there is no wrap-around hazard provided CNT_W is sized as required.

Test Plan (ON_CYC = 4, BLANK_CYC = 1 unless noted):
- Reset, then en = 0 for 20 cycles -> an_n = 1111, digito = 0, bcd_out = 0, frame_tick never pulses.
- en = 1, bcd_in = 16'h1234, lz_en = 0:
  - an_n sequence: 1111 x1, 0111 x4 (bcd_out = 1), 1111 x1, 1011 x4 (2), 1111 x1, 1101 x4 (3), 1111 x1, 1110 x4 (4), then repeats.
  - frame_tick pulses every 20 cycles.
- bcd_in = 16'h0047, lz_en = 1 -> digits 0 and 1 show an_n = 1111 during their slots; 1101 (bcd_out = 4) and 1110 (7) are lit; frame period stays 20 cycles.
- bcd_in = 16'h0000, lz_en = 1 -> only digit 3 is lit (1110, bcd_out = 0).
- Start scanning 16'h1234; change bcd_in to 16'h5678 during digit 1 -> digits 2 and 3 still show 3 and 4; 5, 6, 7, 8 appear only after the frame_tick.
- Deassert en during digit 2 ON -> next edge an_n = 1111, digito = 0.
  - Re-assert en -> restart at digit 0.
  - Pulse reset_n low mid-frame -> outputs reset without waiting for clk.
  - Repeat with BLANK_CYC = 0 -> no 1111 gaps between lit digits, frame period 16 cycles.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// Bus bundle between the display scan controller and its environment.
// Carries the scan controls, the counter value to show and the digit/anode/
// nibble outputs that feed the shared segment decoder and anode drivers.
//
// Signal contract: there is no valid/ready pair on this bus. en and lz_en are
// level controls sampled on every rising clk edge. bcd_in is a free-running
// value that is only captured at frame boundaries. Every output is a register
// that changes only on a rising clk edge or on asynchronous reset.
interface display_scan_ctrl_if;
  logic        en;          // scan enable, low forces display off
  logic        lz_en;       // leading-zero blanking enable
  logic [15:0] bcd_in;      // counter value, [15:12] is the leftmost digit
  logic [1:0]  digito;      // index of the scheduled digit
  logic [3:0]  an_n;        // active-low anode enables {d1,d2,d3,d4}
  logic [3:0]  bcd_out;     // snapshot nibble for the scheduled digit
  logic        frame_tick;  // one-cycle pulse at each frame wrap
  logic [1:0]  dbg_state;   // scan FSM state: 0 OFF, 1 BLANK, 2 ON

  // Environment side: drives controls and the value, observes the scan
  modport master (
    output en, lz_en, bcd_in,
    input  digito, an_n, bcd_out, frame_tick, dbg_state
  );

  // Controller side
  modport slave (
    input  en, lz_en, bcd_in,
    output digito, an_n, bcd_out, frame_tick, dbg_state
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexing scheduler for a 4-digit 7-segment display.
// Each digit gets an anode-off dead time (BLANK) followed by a lit dwell (ON).
// The counter value is captured once per frame so a digit never shows a mix
// of old and new values. Optional leading-zero blanking keeps the slot timing
// and only suppresses the anode.
module display_scan_ctrl #(
  parameter int ON_CYC    = 50000,  // cycles each digit is lit (>= 1)
  parameter int BLANK_CYC = 500,    // dead-time cycles before each digit (>= 0)
  parameter int CNT_W     = 16      // must hold max(ON_CYC, BLANK_CYC) - 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  display_scan_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  localparam bit              HAS_BLANK  = (BLANK_CYC > 0);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);

  state_t           state_q;
  logic [1:0]       digit_q;
  logic [3:0]       an_n_q;
  logic [3:0]       bcd_out_q;
  logic             frame_tick_q;
  logic [15:0]      snap_q;
  logic [CNT_W-1:0] cnt_q;

  // Look-ahead values used when an ON dwell ends
  logic [1:0]       digit_d;
  logic [15:0]      snap_d;
  logic             wrap_d;

  // Select the nibble for a digit index; index 0 is the most significant
  function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    return v[15:12];
      2'd1:    return v[11:8];
      2'd2:    return v[7:4];
      default: return v[3:0];
    endcase
  endfunction

  // Anode pattern for a lit slot, or all-off if the digit is a leading zero
  function automatic logic [3:0] lit_pattern(input logic [1:0] idx, input logic [15:0] v,
                                             input logic lz);
    logic z0;
    logic z1;
    logic z2;
    logic blank;
    z0 = (v[15:12] == 4'h0);
    z1 = z0 && (v[11:8] == 4'h0);
    z2 = z1 && (v[7:4] == 4'h0);
    case (idx)
      2'd0:    blank = lz && z0;
      2'd1:    blank = lz && z1;
      2'd2:    blank = lz && z2;
      default: blank = 1'b0;  // the last digit always shows, even for 0000
    endcase
    if (blank) return 4'b1111;
    return ~(4'b1000 >> idx);
  endfunction

  // Next digit and snapshot at the end of an ON dwell; a wrap reloads the snapshot
  always_comb begin
    wrap_d  = (digit_q == 2'd3);
    digit_d = digit_q + 2'd1;
    snap_d  = wrap_d ? bus.bcd_in : snap_q;
  end

  // Scan FSM with registered outputs; en low overrides any dwell-end transition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_OFF;
      digit_q      <= 2'd0;
      an_n_q       <= 4'b1111;
      bcd_out_q    <= 4'h0;
      frame_tick_q <= 1'b0;
      snap_q       <= 16'h0000;
      cnt_q        <= '0;
    end else begin
      frame_tick_q <= 1'b0;
      if (!bus.en) begin
        state_q   <= ST_OFF;
        digit_q   <= 2'd0;
        cnt_q     <= '0;
        an_n_q    <= 4'b1111;
        bcd_out_q <= nibble(snap_q, 2'd0);
      end else begin
        case (state_q)
          ST_OFF: begin
            // Fresh snapshot on every start so a restart never shows stale data
            snap_q    <= bus.bcd_in;
            digit_q   <= 2'd0;
            cnt_q     <= '0;
            bcd_out_q <= bus.bcd_in[15:12];
            if (HAS_BLANK) begin
              state_q <= ST_BLANK;
              an_n_q  <= 4'b1111;
            end else begin
              state_q <= ST_ON;
              an_n_q  <= lit_pattern(2'd0, bus.bcd_in, bus.lz_en);
            end
          end

          ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
              state_q <= ST_ON;
              cnt_q   <= '0;
              an_n_q  <= lit_pattern(digit_q, snap_q, bus.lz_en);
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              an_n_q  <= 4'b1111;
            end
          end

          ST_ON: begin
            if (cnt_q == ON_LAST) begin
              cnt_q        <= '0;
              digit_q      <= digit_d;
              snap_q       <= snap_d;
              bcd_out_q    <= nibble(snap_d, digit_d);
              frame_tick_q <= wrap_d;
              if (HAS_BLANK) begin
                state_q <= ST_BLANK;
                an_n_q  <= 4'b1111;
              end else begin
                state_q <= ST_ON;
                an_n_q  <= lit_pattern(digit_d, snap_d, bus.lz_en);
              end
            end else begin
              // lz_en is re-evaluated every cycle; only the anode can change
              cnt_q  <= cnt_q + 1'b1;
              an_n_q <= lit_pattern(digit_q, snap_q, bus.lz_en);
            end
          end

          default: begin
            state_q <= ST_OFF;
            digit_q <= 2'd0;
            cnt_q   <= '0;
            an_n_q  <= 4'b1111;
          end
        endcase
      end
    end
  end

  assign bus.digito     = digit_q;
  assign bus.an_n       = an_n_q;
  assign bus.bcd_out    = bcd_out_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl. dut_a runs ON_CYC=4, BLANK_CYC=1
// (20-cycle frame); dut_b runs ON_CYC=4, BLANK_CYC=0 (16-cycle frame).
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_display_scan_ctrl;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  display_scan_ctrl_if bus_a ();
  display_scan_ctrl_if bus_b ();

  display_scan_ctrl #(.ON_CYC(4), .BLANK_CYC(1), .CNT_W(16)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  display_scan_ctrl #(.ON_CYC(4), .BLANK_CYC(0), .CNT_W(16)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {an_n, digito, bcd_out, frame_tick} for cycle c of a frame.
  // an_tab holds the four lit-slot patterns, slot 0 in the top nibble;
  // nibs holds the four snapshot nibbles, digit 0 in the top nibble.
  function automatic logic [10:0] exp_vec(input logic [15:0] an_tab, input logic [15:0] nibs,
                                          input int c, input int period, input int blank,
                                          input bit tick_ok);
    int         d;
    int         ph;
    logic [1:0] dig;
    logic [3:0] an;
    logic [3:0] nib;
    d   = c / period;
    ph  = c % period;
    dig = d[1:0];
    an  = (ph < blank) ? 4'hf : an_tab[(3 - d) * 4 +: 4];
    nib = nibs[(3 - d) * 4 +: 4];
    return {an, dig, nib, (c == 0) && tick_ok};
  endfunction

  task automatic test_reset();
    logic [10:0] got;
    reset_n      = 1'b0;
    bus_a.en     = 1'b0;
    bus_a.lz_en  = 1'b0;
    bus_a.bcd_in = 16'h0000;
    bus_b.en     = 1'b0;
    bus_b.lz_en  = 1'b0;
    bus_b.bcd_in = 16'h0000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got = {bus_a.an_n, bus_a.digito, bus_a.bcd_out, bus_a.frame_tick};
      n_total++;
      if (got !== {4'hf, 2'd0, 4'h0, 1'b0})
        $display("FAIL reset_idle cyc%0d: got an/dig/bcd/ft=%b want 11110000000", i, got);
      else n_pass++;
    end
    n_total++;
    if (bus_a.dbg_state !== 2'd0)
      $display("FAIL reset_state: got %0d want 0", bus_a.dbg_state);
    else n_pass++;
    got = {bus_b.an_n, bus_b.digito, bus_b.bcd_out, bus_b.frame_tick};
    n_total++;
    if (got !== {4'hf, 2'd0, 4'h0, 1'b0})
      $display("FAIL reset_idle_b: got %b want 11110000000", got);
    else n_pass++;
  endtask

  task automatic test_scan_basic();
    logic [10:0] got;
    logic [10:0] want;
    logic [6:0]  got_off;
    bus_a.bcd_in = 16'h1234;
    bus_a.lz_en  = 1'b0;
    bus_a.en     = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        got  = {bus_a.an_n, bus_a.digito, bus_a.bcd_out, bus_a.frame_tick};
        want = exp_vec(16'h7BDE, 16'h1234, c, 5, 1, f > 0);
        n_total++;
        if (got !== want)
          $display("FAIL basic f%0d c%0d: got %b want %b", f, c, got, want);
        else n_pass++;
      end
    end
    // en drops on the very cycle digit 3 ends: OFF wins, no frame_tick
    bus_a.en = 1'b0;
    @(negedge clk);
    got_off = {bus_a.an_n, bus_a.digito, bus_a.frame_tick};
    n_total++;
    if (got_off !== {4'hf, 2'd0, 1'b0})
      $display("FAIL basic_off_at_wrap: got an/dig/ft=%b want 1111000", got_off);
    else n_pass++;
  endtask

  task automatic test_lz_partial();
    logic [10:0] got;
    logic [10:0] want;
    bus_a.bcd_in = 16'h0047;
    bus_a.lz_en  = 1'b1;
    bus_a.en     = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        got  = {bus_a.an_n, bus_a.digito, bus_a.bcd_out, bus_a.frame_tick};
        want = exp_vec(16'hFFDE, 16'h0047, c, 5, 1, f > 0);
        n_total++;
        if (got !== want)
          $display("FAIL lz_0047 f%0d c%0d: got %b want %b", f, c, got, want);
        else n_pass++;
      end
    end
    bus_a.en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lz_all_zero();
    logic [10:0] got;
    logic [10:0] want;
    bus_a.bcd_in = 16'h0000;
    bus_a.lz_en  = 1'b1;
    bus_a.en     = 1'b1;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      got  = {bus_a.an_n, bus_a.digito, bus_a.bcd_out, bus_a.frame_tick};
      want = exp_vec(16'hFFFE, 16'h0000, c % 20, 5, 1, c == 20);
      n_total++;
      if (got !== want)
        $display("FAIL lz_0000 c%0d: got %b want %b", c, got, want);
      else n_pass++;
    end
    bus_a.en    = 1'b0;
    bus_a.lz_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_snapshot();
    logic [10:0] got;
    logic [10:0] want;
    bus_a.bcd_in = 16'h1234;
    bus_a.lz_en  = 1'b0;
    bus_a.en     = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        got  = {bus_a.an_n, bus_a.digito, bus_a.bcd_out, bus_a.frame_tick};
        want = exp_vec(16'h7BDE, (f == 0) ? 16'h1234 : 16'h5678, c, 5, 1, f > 0);
        n_total++;
        if (got !== want)
          $display("FAIL snapshot f%0d c%0d: got %b want %b", f, c, got, want);
        else n_pass++;
        if (f == 0 && c == 7) bus_a.bcd_in = 16'h5678;  // mid digit 1
      end
    end
    bus_a.en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_en_drop();
    logic [10:0] got;
    logic [10:0] want;
    logic [6:0]  got_off;
    bus_a.bcd_in = 16'h1234;
    bus_a.en     = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      got  = {bus_a.an_n, bus_a.digito, bus_a.bcd_out, bus_a.frame_tick};
      want = exp_vec(16'h7BDE, 16'h1234, c, 5, 1, 1'b0);
      n_total++;
      if (got !== want)
        $display("FAIL en_drop_pre c%0d: got %b want %b", c, got, want);
      else n_pass++;
    end
    bus_a.en = 1'b0;  // digit 2 is lit here
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got_off = {bus_a.an_n, bus_a.digito, bus_a.frame_tick};
      n_total++;
      if (got_off !== {4'hf, 2'd0, 1'b0} || bus_a.dbg_state !== 2'd0)
        $display("FAIL en_drop_off cyc%0d: got an/dig/ft=%b state=%0d want 1111000 state=0",
                 i, got_off, bus_a.dbg_state);
      else n_pass++;
    end
    bus_a.bcd_in = 16'h9876;
    bus_a.en     = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      got  = {bus_a.an_n, bus_a.digito, bus_a.bcd_out, bus_a.frame_tick};
      want = exp_vec(16'h7BDE, 16'h9876, c, 5, 1, 1'b0);
      n_total++;
      if (got !== want)
        $display("FAIL en_restart c%0d: got %b want %b", c, got, want);
      else n_pass++;
    end
    bus_a.en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [10:0] got;
    logic [10:0] want;
    bus_a.bcd_in = 16'h1234;
    bus_a.en     = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      got  = {bus_a.an_n, bus_a.digito, bus_a.bcd_out, bus_a.frame_tick};
      want = exp_vec(16'h7BDE, 16'h1234, c, 5, 1, 1'b0);
      n_total++;
      if (got !== want)
        $display("FAIL areset_pre c%0d: got %b want %b", c, got, want);
      else n_pass++;
    end
    // Assert reset between clock edges and look before the next rising edge
    #2 reset_n = 1'b0;
    #1;
    got = {bus_a.an_n, bus_a.digito, bus_a.bcd_out, bus_a.frame_tick};
    n_total++;
    if (got !== {4'hf, 2'd0, 4'h0, 1'b0} || bus_a.dbg_state !== 2'd0)
      $display("FAIL areset_now: got %b state=%0d want 11110000000 state=0",
               got, bus_a.dbg_state);
    else n_pass++;
    bus_a.en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    got = {bus_a.an_n, bus_a.digito, bus_a.bcd_out, bus_a.frame_tick};
    n_total++;
    if (got !== {4'hf, 2'd0, 4'h0, 1'b0})
      $display("FAIL areset_after: got %b want 11110000000", got);
    else n_pass++;
  endtask

  task automatic test_no_blank();
    logic [10:0] got;
    logic [10:0] want;
    bus_b.bcd_in = 16'h1234;
    bus_b.lz_en  = 1'b0;
    bus_b.en     = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        got  = {bus_b.an_n, bus_b.digito, bus_b.bcd_out, bus_b.frame_tick};
        want = exp_vec(16'h7BDE, 16'h1234, c, 4, 0, f > 0);
        n_total++;
        if (got !== want)
          $display("FAIL noblank f%0d c%0d: got %b want %b", f, c, got, want);
        else n_pass++;
      end
    end
    bus_b.en = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus_b.an_n !== 4'hf || bus_b.digito !== 2'd0)
      $display("FAIL noblank_off: got an=%b dig=%0d want an=1111 dig=0",
               bus_b.an_n, bus_b.digito);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_scan_basic();
    test_lz_partial();
    test_lz_all_zero();
    test_snapshot();
    test_en_drop();
    test_async_reset();
    test_no_blank();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
